// File: rtl/adder_tree_loader_if.sv
// Serial word stream into the adder tree loader: valid/ready with a
// short-frame terminator.
interface adder_tree_loader_if #(
  parameter int DATA_W = 3
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;

  modport master (output s_valid, output s_data, output s_last, input  s_ready);
  modport slave  (input  s_valid, input  s_data, input  s_last, output s_ready);
endinterface

// File: rtl/adder_tree_loader.sv
// Adder tree loader: collects a serial word stream into a DATA_N-wide vector,
// launches it onto the tree input, and tags the tree output cycle carrying the
// frame sum with a valid/nwords pair delayed by the tree latency.
module adder_tree_loader #(
  parameter int DATA_W   = 3,
  parameter int DATA_N   = 21,
  parameter int TREE_LAT = 7,
  parameter int CNT_W    = 16,
  localparam int IDX_W   = (DATA_N > 1) ? $clog2(DATA_N) : 1,
  localparam int NW_W    = $clog2(DATA_N + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  adder_tree_loader_if.slave            s,
  input  logic                          i_tree_en,
  output logic [0:DATA_N-1][DATA_W-1:0] o_data,
  output logic                          o_vec_valid,
  output logic                          o_sum_valid,
  output logic [NW_W-1:0]               o_sum_nwords,
  output logic [CNT_W-1:0]              o_frame_cnt
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                         state;
  logic                           rdy_q;
  logic [IDX_W-1:0]               widx;
  logic [0:DATA_N-1][DATA_W-1:0]  col_buf;
  logic [0:DATA_N-1][DATA_W-1:0]  merged;
  logic [NW_W-1:0]                hold_nw;
  logic [TREE_LAT:0]              vld_pipe;
  logic [TREE_LAT:0][NW_W-1:0]    nw_pipe;

  logic            accept, complete, launch;
  logic [NW_W-1:0] cur_nw, launch_nw;

  assign s.s_ready = rdy_q;
  assign accept    = s.s_valid & rdy_q;
  assign complete  = accept & ((widx == IDX_W'(DATA_N - 1)) | s.s_last);
  assign cur_nw    = NW_W'(widx) + NW_W'(1);
  assign launch    = i_tree_en & ((state == HOLD) | ((state == FILL) & complete));
  assign launch_nw = (state == HOLD) ? hold_nw : cur_nw;

  // Buffer merged with the incoming word; unwritten lanes are already zero
  // because the buffer is cleared on every launch.
  for (genvar g = 0; g < DATA_N; g++) begin : g_lane
    assign merged[g] = (accept && widx == IDX_W'(g)) ? s.s_data : col_buf[g];
  end

  // Frame assembly, hold/launch control and launch output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FILL;
      rdy_q       <= 1'b0;
      widx        <= '0;
      col_buf     <= '0;
      hold_nw     <= '0;
      o_data      <= '0;
      o_frame_cnt <= '0;
    end else begin
      rdy_q <= 1'b1;
      case (state)
        FILL: begin
          if (complete) begin
            if (i_tree_en) begin
              o_data  <= merged;
              col_buf <= '0;
              widx    <= '0;
            end else begin
              col_buf <= merged;
              hold_nw <= cur_nw;
              state   <= HOLD;
              rdy_q   <= 1'b0;
            end
          end else if (accept) begin
            col_buf <= merged;
            widx    <= widx + IDX_W'(1);
          end
        end
        HOLD: begin
          if (i_tree_en) begin
            o_data  <= col_buf;
            col_buf <= '0;
            widx    <= '0;
            state   <= FILL;
          end else begin
            rdy_q   <= 1'b0;
          end
        end
        default: state <= FILL;
      endcase
      if (launch) o_frame_cnt <= o_frame_cnt + CNT_W'(1);
    end
  end

  // Launch tag delay line: stage 0 is the launch pulse, stage TREE_LAT lines
  // up with the tree output carrying that frame's sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      nw_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[TREE_LAT-1:0], launch};
      nw_pipe  <= {nw_pipe[TREE_LAT-1:0], (launch ? launch_nw : NW_W'(0))};
    end
  end

  assign o_vec_valid  = vld_pipe[0];
  assign o_sum_valid  = vld_pipe[TREE_LAT];
  assign o_sum_nwords = nw_pipe[TREE_LAT];

endmodule

// File: tb/tb_adder_tree_loader.sv
// Directed bench for adder_tree_loader with hand-computed expectations.
module tb_adder_tree_loader;
  localparam int DATA_W = 3;
  localparam int DATA_N = 21;
  localparam int NW_W   = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic i_tree_en;
  logic [0:DATA_N-1][DATA_W-1:0] o_data;
  logic o_vec_valid, o_sum_valid;
  logic [NW_W-1:0] o_sum_nwords;
  logic [15:0] o_frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  adder_tree_loader_if #(.DATA_W(DATA_W)) s_if ();

  adder_tree_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s            (s_if.slave),
    .i_tree_en    (i_tree_en),
    .o_data       (o_data),
    .o_vec_valid  (o_vec_valid),
    .o_sum_valid  (o_sum_valid),
    .o_sum_nwords (o_sum_nwords),
    .o_frame_cnt  (o_frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [DATA_W-1:0] d, input logic l);
    s_if.s_valid = 1'b1;
    s_if.s_data  = d;
    s_if.s_last  = l;
    tick();
    s_if.s_valid = 1'b0;
    s_if.s_last  = 1'b0;
  endtask

  logic [0:DATA_N-1][DATA_W-1:0] ev, prev;
  logic flag_a, flag_b;

  initial begin
    rst_n = 1'b0;
    i_tree_en = 1'b1;
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    s_if.s_last  = 1'b0;

    // reset state
    #12;
    chk("rst_ready", 64'(s_if.s_ready), 0);
    chk("rst_data",  64'(o_data), 0);
    chk("rst_cnt",   64'(o_frame_cnt), 0);
    chk("rst_vv",    64'({o_vec_valid, o_sum_valid, o_sum_nwords}), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", 64'(s_if.s_ready), 1);

    // full 21-word frame, data k mod 8
    ev = '0; flag_a = 1'b0; flag_b = 1'b0;
    for (int k = 1; k <= DATA_N; k++) begin
      ev[k-1] = DATA_W'(k % 8);
      if (s_if.s_ready !== 1'b1) flag_a = 1'b1;
      if (k > 1 && o_vec_valid !== 1'b0) flag_b = 1'b1;
      beat(DATA_W'(k % 8), 1'b0);
    end
    chk("full_ready", 64'(flag_a), 0);
    chk("full_early_vv", 64'(flag_b), 0);
    chk("full_vv", 64'(o_vec_valid), 1);
    chk("full_d0", 64'(o_data[0]), 1);
    chk("full_d20", 64'(o_data[20]), 5);
    chk("full_data", 64'(o_data), 64'(ev));
    chk("full_cnt", 64'(o_frame_cnt), 1);
    flag_a = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (o_sum_valid) flag_a = 1'b1;
    end
    chk("full_sum_early", 64'(flag_a), 0);
    tick();
    chk("full_sum_vld", 64'(o_sum_valid), 1);
    chk("full_sum_nw", 64'(o_sum_nwords), 21);
    tick();
    chk("full_sum_once", 64'(o_sum_valid), 0);

    // short frame: five 7s, s_last on the 5th
    for (int k = 0; k < 5; k++) beat(3'd7, k == 4);
    ev = '0;
    for (int k = 0; k < 5; k++) ev[k] = 3'd7;
    chk("short_vv", 64'(o_vec_valid), 1);
    chk("short_data", 64'(o_data), 64'(ev));
    chk("short_cnt", 64'(o_frame_cnt), 2);
    for (int i = 0; i < 7; i++) tick();
    chk("short_sum_vld", 64'(o_sum_valid), 1);
    chk("short_sum_nw", 64'(o_sum_nwords), 5);

    // full frame with downstream stalled for 10 cycles
    prev = o_data;
    i_tree_en = 1'b0;
    ev = '0;
    for (int k = 1; k <= DATA_N; k++) begin
      ev[k-1] = DATA_W'((k * 3) % 8);
      beat(DATA_W'((k * 3) % 8), 1'b0);
    end
    chk("hold_no_launch", 64'(o_vec_valid), 0);
    s_if.s_valid = 1'b1;
    s_if.s_data  = 3'd6;
    flag_a = 1'b0; flag_b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (s_if.s_ready !== 1'b0) flag_a = 1'b1;
      if (o_data !== prev) flag_b = 1'b1;
      tick();
    end
    chk("hold_ready_low", 64'(flag_a), 0);
    chk("hold_data_stable", 64'(flag_b), 0);
    i_tree_en = 1'b1;
    tick();
    s_if.s_valid = 1'b0;
    chk("hold_launch_vv", 64'(o_vec_valid), 1);
    chk("hold_launch_data", 64'(o_data), 64'(ev));
    chk("hold_ready_back", 64'(s_if.s_ready), 1);
    chk("hold_cnt", 64'(o_frame_cnt), 3);
    for (int i = 0; i < 7; i++) tick();
    chk("hold_sum_nw", 64'({o_sum_valid, o_sum_nwords}), 64'({1'b1, 5'd21}));

    // four back-to-back single-word frames
    flag_a = 1'b0;
    for (int d = 1; d <= 4; d++) begin
      beat(DATA_W'(d), 1'b1);
      ev = '0;
      ev[0] = DATA_W'(d);
      if (o_vec_valid !== 1'b1 || o_data !== ev) flag_a = 1'b1;
    end
    chk("b2b_vec", 64'(flag_a), 0);
    chk("b2b_cnt", 64'(o_frame_cnt), 7);
    flag_a = 1'b0; flag_b = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i <= 3 || i == 8) begin
        if (o_sum_valid !== 1'b0) flag_a = 1'b1;
      end else begin
        if (o_sum_valid !== 1'b1 || o_sum_nwords !== 5'd1) flag_b = 1'b1;
      end
    end
    chk("b2b_sum_gap", 64'(flag_a), 0);
    chk("b2b_sum_run", 64'(flag_b), 0);

    // reset in the middle of a frame
    for (int k = 0; k < 10; k++) beat(3'd3, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out", 64'({o_vec_valid, o_sum_valid, o_sum_nwords, o_frame_cnt}), 0);
    chk("mid_rst_data", 64'(o_data), 0);
    chk("mid_rst_ready", 64'(s_if.s_ready), 0);
    tick();
    rst_n = 1'b1;
    tick();
    beat(3'd5, 1'b1);
    ev = '0;
    ev[0] = 3'd5;
    chk("post_rst_frame", 64'(o_data), 64'(ev));
    chk("post_rst_cnt", 64'(o_frame_cnt), 1);

    // reset three cycles after a launch: tag must never emerge
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("flight_rst_out", 64'({o_vec_valid, o_sum_valid, o_frame_cnt}), 0);
    chk("flight_rst_data", 64'(o_data), 0);
    tick();
    rst_n = 1'b1;
    flag_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (o_sum_valid) flag_a = 1'b1;
    end
    chk("flight_no_sum", 64'(flag_a), 0);

    // frame counter wrap
    s_if.s_valid = 1'b1;
    s_if.s_last  = 1'b1;
    s_if.s_data  = 3'd1;
    for (int i = 0; i < 65535; i++) @(posedge clk);
    #1;
    chk("cnt_max", 64'(o_frame_cnt), 65535);
    tick();
    s_if.s_valid = 1'b0;
    s_if.s_last  = 1'b0;
    chk("cnt_wrap", 64'(o_frame_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/adder_tree_loader.md
Name: adder_tree_loader

Overview:
- Upstream feeder for the CSA adder tree.
- Accepts a serial stream of DATA_W-bit words over a valid/ready handshake and assembles them into a DATA_N-word parallel vector. Short frames are zero-padded.
- Launches each vector onto the tree's parallel input and holds it there until the next launch.
- Tags each launch with a valid bit delayed by the tree's pipeline latency, so the downstream consumer knows which tree output cycle carries a real frame sum.

Parameters:
- DATA_W, 3: width of each input word; must match the tree's DATA_W.
- DATA_N, 21: words per vector; must match the tree's DATA_N.
- TREE_LAT, 7: clock cycles from the tree input to a valid tree output. Must be >= 1; 7 is the tree latency for DATA_N=21.
- CNT_W, 16: width of the frame counter.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- s_valid, input, 1: upstream word valid.
- s_ready, output, 1: loader can accept a word.
- s_data, input, DATA_W: upstream word.
- s_last, input, 1: marks the final word of a short frame; sampled only on an accepted beat.
- i_tree_en, input, 1: downstream permits a new launch this cycle.
- o_data, output, DATA_N*DATA_W: packed vector [0:DATA_N-1][DATA_W-1:0] that drives the tree's i_data.
- o_vec_valid, output, 1: one-cycle pulse; o_data changed to a new frame this cycle.
- o_sum_valid, output, 1: o_vec_valid delayed exactly TREE_LAT cycles.
- o_sum_nwords, output, $clog2(DATA_N+1): real word count of the frame whose sum is valid now.
- o_frame_cnt, output, CNT_W: number of launched frames; wraps to 0 after the maximum value.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State FILL, write index 0, collect buffer 0.
  - Outputs: o_data 0, o_vec_valid 0, o_sum_valid 0, o_sum_nwords 0, o_frame_cnt 0, and the delay line cleared.
  - s_ready is 0 while rst_n is low and becomes 1 on the first cycle after release.
  - Reset asserted mid-frame discards the partial frame and every in-flight delay-line entry. No o_sum_valid may fire after release for a frame launched before reset.
- Accept and ordering:
  - A beat is accepted when s_valid and s_ready are both high.
  - The first accepted word of a frame goes to o_data[0], the k-th to o_data[k-1].
  - s_ready = (state == FILL).
- Frame complete: an accepted beat with write index == DATA_N-1, or with s_last high.
  - Positions after the last written index are zero.
  - nwords = last index + 1, range 1..DATA_N.
  - s_last on beat DATA_N has the same effect as a normal full frame.
- States:
  - FILL, frame completes and i_tree_en=1 in the same cycle: launch at that edge. o_data takes the buffer merged with the incoming word. Stay in FILL, write index 0, buffer cleared.
  - FILL, frame completes and i_tree_en=0: latch the completed frame and go to HOLD. s_ready=0 in HOLD.
  - HOLD, i_tree_en=1: launch at the edge, go to FILL.
  - HOLD, i_tree_en=0: remain in HOLD. o_data keeps the previous frame and no words are accepted.
- Launch:
  - o_vec_valid=1 for exactly the cycle after the launch edge, then 0 unless another launch follows.
  - o_frame_cnt increments by 1.
  - o_data is stable between launches; it is never cleared except by reset.
- Delay line:
  - TREE_LAT-deep shift register of {valid, nwords}, advancing every cycle unconditionally.
  - o_sum_valid / o_sum_nwords are its tail.
  - Back-to-back launches (possible with s_last on every beat) produce back-to-back o_sum_valid pulses with no merging or loss.
- Throughput:
  - One launch per DATA_N accepted beats for full frames.
  - Up to one launch per cycle for 1-word frames, provided i_tree_en stays high.
- s_valid low mid-frame: the partial frame is held indefinitely and the write index does not change.

Test Plan:
- Reset release, then 21 beats with s_data=1..21 (mod 8), s_valid=1, i_tree_en=1 -> s_ready=1 throughout. o_vec_valid pulses once after beat 21 with o_data[0]=1, o_data[20]=5. o_sum_valid fires exactly 7 cycles later with nwords=21. o_frame_cnt=1.
- 5 beats of value 7 with s_last on the 5th -> o_data[0..4]=7, o_data[5..20]=0, o_sum_nwords=5.
- Full frame completes with i_tree_en=0 for 10 cycles -> s_ready=0 and o_data unchanged for those 10 cycles. Launch occurs on the cycle i_tree_en rises, and s_ready returns to 1 the next cycle.
- s_last on 4 consecutive single beats, i_tree_en=1 -> 4 consecutive o_vec_valid cycles, then 4 consecutive o_sum_valid cycles 7 cycles later, each with nwords=1. o_frame_cnt advances by 4.
- rst_n pulsed low after beat 10, and again 3 cycles after a launch -> all outputs 0 immediately. No o_sum_valid after release. The next frame starts at o_data[0].
- Preload o_frame_cnt to 65535 via 65535 launches of 1-word frames, then launch 1 more -> o_frame_cnt=0.
